// File: rtl/fp16_minmax_tracker.sv
// fp16_minmax_tracker: per-frame fp16 min/max/count tracker with valid/ready result handshake
module fp16_minmax_tracker #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [15:0]      in_data,
  input  logic             in_valid,
  input  logic             in_last,
  output logic             in_ready,
  output logic [15:0]      out_min,
  output logic [15:0]      out_max,
  output logic [CNT_W-1:0] out_count,
  output logic [CNT_W-1:0] out_nan,
  output logic             out_empty,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [2:0]       last_cmp
);
  typedef enum logic [1:0] {IDLE, ACCUM, HOLD} state_t;
  localparam logic [2:0] LT = 3'b100, GT = 3'b010, EQ = 3'b001;
  state_t state;
  logic [15:0] min_r, max_r, prev_r;
  logic [CNT_W-1:0] cnt, nan_cnt;
  logic acc, nan;
  logic [2:0] c_prev, c_min, c_max;
  function automatic logic [2:0] rel(input logic [15:0] a, input logic [15:0] b);
    logic a_big;
    a_big = a[14:0] > b[14:0];
    return (a[14:0] == 15'd0 && b[14:0] == 15'd0) || a == b ? EQ :
           a[15] != b[15] ? (a[15] ? LT : GT) :
           (a_big ^ a[15]) ? GT : LT;
  endfunction
  assign in_ready  = state != HOLD;
  assign out_valid = state == HOLD;
  assign acc       = in_valid && in_ready;
  assign nan       = &in_data[14:10] && |in_data[9:0];
  assign c_prev    = rel(in_data, prev_r);
  assign c_min     = rel(in_data, min_r);
  assign c_max     = rel(in_data, max_r);
  assign out_min   = min_r;
  assign out_max   = max_r;
  assign out_count = cnt;
  assign out_nan   = nan_cnt;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      min_r     <= '0;
      max_r     <= '0;
      prev_r    <= '0;
      cnt       <= '0;
      nan_cnt   <= '0;
      out_empty <= 1'b0;
      last_cmp  <= 3'b000;
    end else if (state == HOLD) begin
      if (out_ready) begin
        state     <= IDLE;
        min_r     <= '0;
        max_r     <= '0;
        prev_r    <= '0;
        cnt       <= '0;
        nan_cnt   <= '0;
        out_empty <= 1'b0;
        last_cmp  <= 3'b000;
      end
    end else if (acc) begin
      if (nan) begin
        nan_cnt  <= nan_cnt + CNT_W'(~&nan_cnt);
        last_cmp <= 3'b000;
      end else if (state == IDLE) begin
        min_r    <= in_data;
        max_r    <= in_data;
        prev_r   <= in_data;
        cnt      <= CNT_W'(1);
        last_cmp <= 3'b000;
      end else begin
        // ties leave the stored extremum alone so the first occurrence wins
        if (c_min == LT) min_r <= in_data;
        if (c_max == GT) max_r <= in_data;
        prev_r   <= in_data;
        cnt      <= cnt + CNT_W'(~&cnt);
        last_cmp <= c_prev;
      end
      if (in_last) begin
        state <= HOLD;
        if (state == IDLE && nan) begin
          out_empty <= 1'b1;
          min_r     <= 16'h7E00;
          max_r     <= 16'h7E00;
        end
      end else if (!nan) begin
        state <= ACCUM;
      end
    end
  end
endmodule

// File: tb/tb_fp16_minmax_tracker.sv
// tb_fp16_minmax_tracker: directed plus random stimulus against a queue-based model of frame extrema
module tb_fp16_minmax_tracker;
  logic clk = 0, rst_n = 0;
  logic [15:0] in_data = '0;
  logic in_valid = 0, in_last = 0, out_ready = 0;
  logic in_ready, out_empty, out_valid;
  logic [15:0] out_min, out_max;
  logic [7:0] out_count, out_nan;
  logic [2:0] last_cmp;
  int total = 0, bad = 0;

  fp16_minmax_tracker #(.CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid), .in_last(in_last),
    .in_ready(in_ready), .out_min(out_min), .out_max(out_max), .out_count(out_count),
    .out_nan(out_nan), .out_empty(out_empty), .out_valid(out_valid), .out_ready(out_ready),
    .last_cmp(last_cmp)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: non-NaN values map to signed integer keys, so ordering is plain integer comparison.
  function automatic int key(input logic [15:0] x);
    return x[15] ? -int'(x[14:0]) : int'(x[14:0]);
  endfunction
  function automatic logic [2:0] mrel(input logic [15:0] a, input logic [15:0] b);
    return key(a) < key(b) ? 3'b100 : key(a) > key(b) ? 3'b010 : 3'b001;
  endfunction
  function automatic bit is_nan(input logic [15:0] x);
    return x[14:10] == 5'h1F && x[9:0] != 0;
  endfunction

  logic [15:0] q[$];
  int nanc = 0;
  logic [2:0] m_lc = 0;
  bit m_hold = 0, m_empty = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q.delete(); nanc = 0; m_lc = 0; m_hold = 0; m_empty = 0;
    end else if (m_hold) begin
      if (out_ready) begin
        q.delete(); nanc = 0; m_lc = 0; m_hold = 0; m_empty = 0;
      end
    end else if (in_valid) begin
      if (is_nan(in_data)) begin
        nanc++; m_lc = 0;
      end else begin
        m_lc = q.size() == 0 ? 3'b000 : mrel(in_data, q[$]);
        q.push_back(in_data);
      end
      if (in_last) begin
        m_hold = 1; m_empty = q.size() == 0;
      end
    end
  end

  function automatic logic [15:0] m_ext(input bit want_max);
    logic [15:0] r;
    if (m_empty) return 16'h7E00;
    if (q.size() == 0) return 16'h0000;
    r = q[0];
    foreach (q[i]) if (want_max ? key(q[i]) > key(r) : key(q[i]) < key(r)) r = q[i];
    return r;
  endfunction

  always @(negedge clk) begin
    chk("m_in_ready", in_ready, !m_hold);
    chk("m_out_valid", out_valid, m_hold);
    chk("m_last_cmp", last_cmp, m_lc);
    chk("m_count", out_count, q.size() > 255 ? 255 : q.size());
    chk("m_nan", out_nan, nanc > 255 ? 255 : nanc);
    chk("m_empty", out_empty, m_empty);
    chk("m_min", out_min, m_ext(0));
    chk("m_max", out_max, m_ext(1));
  end

  task automatic put(input logic [15:0] d, input bit l);
    int k = 0;
    in_data = d; in_last = l; in_valid = 1;
    @(negedge clk);
    while (!in_ready && k < 50) begin @(negedge clk); k++; end
    if (!in_ready) chk("put_ready", in_ready, 1);
    @(posedge clk); #1;
  endtask

  task automatic take(input logic [15:0] mn, input logic [15:0] mx, input int c, input int n, input bit e, input string nm);
    int k = 0;
    @(negedge clk);
    while (!out_valid && k < 50) begin @(negedge clk); k++; end
    chk({nm, "_valid"}, out_valid, 1);
    chk({nm, "_min"}, out_min, mn);
    chk({nm, "_max"}, out_max, mx);
    chk({nm, "_count"}, out_count, c);
    chk({nm, "_nan"}, out_nan, n);
    chk({nm, "_empty"}, out_empty, e);
    out_ready = 1;
    @(posedge clk); #1 out_ready = 0;
  endtask

  logic [15:0] pool[10] = '{16'h0000, 16'h8000, 16'h3C00, 16'hBC00, 16'h7C00,
                            16'hFC00, 16'h7E00, 16'h7C01, 16'hFFFF, 16'h4000};

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_min", out_min, 16'h0000);
    chk("rst_ready", in_ready, 1);
    chk("rst_valid", out_valid, 0);
    @(posedge clk); #1 rst_n = 1;
    put(16'h3C00, 0); chk("basic_lc0", last_cmp, 3'b000);
    put(16'h4000, 0); chk("basic_lc1", last_cmp, 3'b010);
    put(16'hBC00, 1); chk("basic_lc2", last_cmp, 3'b100);
    in_valid = 0;
    @(negedge clk); chk("basic_latency", out_valid, 1);
    take(16'hBC00, 16'h4000, 3, 0, 0, "basic");
    put(16'h8000, 0); put(16'h0000, 1); chk("zero_lc", last_cmp, 3'b001);
    in_valid = 0;
    take(16'h8000, 16'h8000, 2, 0, 0, "zeros");
    put(16'h7E00, 0); put(16'hC000, 0); put(16'h7C00, 0); put(16'h7E01, 1);
    chk("naninf_lc", last_cmp, 3'b000);
    in_valid = 0;
    take(16'hC000, 16'h7C00, 2, 2, 0, "naninf");
    put(16'h7E00, 1); in_valid = 0;
    take(16'h7E00, 16'h7E00, 0, 1, 1, "allnan");
    put(16'h4000, 1); in_last = 0;
    repeat (5) begin
      @(negedge clk);
      chk("bp_ready", in_ready, 0);
      chk("bp_valid", out_valid, 1);
      chk("bp_count", out_count, 1);
      chk("bp_max", out_max, 16'h4000);
    end
    out_ready = 1;
    @(posedge clk); #1 out_ready = 0;
    @(negedge clk);
    chk("bp_release_valid", out_valid, 0);
    chk("bp_release_ready", in_ready, 1);
    @(posedge clk); #1;
    put(16'h3C00, 0); in_valid = 0;
    chk("pre_rst_count", out_count, 2);
    rst_n = 0;
    #1 chk("rst_mid_count", out_count, 0);
    @(posedge clk); #1 rst_n = 1;
    put(16'h4000, 1); in_valid = 0;
    take(16'h4000, 16'h4000, 1, 0, 0, "after_rst");
    for (int i = 0; i < 300; i++) put(16'h3C00, i == 299);
    in_valid = 0;
    take(16'h3C00, 16'h3C00, 255, 0, 0, "sat");
    for (int i = 0; i < 3000; i++) begin
      in_valid = $urandom_range(0, 3) != 0;
      in_data = $urandom_range(0, 2) == 0 ? 16'($urandom) : pool[$urandom_range(0, 9)];
      in_last = $urandom_range(0, 7) == 0;
      out_ready = $urandom_range(0, 2) != 0;
      rst_n = $urandom_range(0, 499) != 0;
      @(posedge clk); #1;
    end
    in_valid = 0; rst_n = 1; out_ready = 1;
    repeat (3) @(posedge clk);
    #1 $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/fp16_minmax_tracker.md
# fp16_minmax_tracker

Streaming consumer of half-precision (1/5/10) operands. Orders each accepted sample against the running extrema with the team's one-hot relation code (3'b100 less, 3'b010 greater, 3'b001 equal) and reports frame minimum, maximum and counts through a valid/ready output handshake. It sits downstream of the FPU datapath as the selection end of the comparison path: the comparator produces relation codes, and this block acts on them.

## Interface
Parameters:
- CNT_W, 8: width of the saturating sample and NaN counters.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- in_data  input  16  fp16 sample: sign [15], exponent [14:10], mantissa [9:0].
- in_valid  input  1  sample present.
- in_last  input  1  sample closes the frame; qualified by in_valid.
- in_ready  output  1  block accepts a sample this cycle.
- out_min  output  16  frame minimum.
- out_max  output  16  frame maximum.
- out_count  output  CNT_W  non-NaN samples in the frame, saturating.
- out_nan  output  CNT_W  NaN samples in the frame, saturating.
- out_empty  output  1  frame contained no non-NaN sample.
- out_valid  output  1  frame result present.
- out_ready  input  1  downstream takes the result.
- last_cmp  output  3  relation of the latest accepted non-NaN sample to the previous non-NaN sample of the same frame.

## Operation
- Accept condition: in_valid && in_ready.
- NaN: exponent 5'h1F with mantissa != 0.
  - Increments the NaN counter only.
  - Never enters min/max.
  - Sets last_cmp to 3'b000.
- Ordering rule for non-NaN operands a, b:
  - Both magnitudes (bits [14:0]) zero: equal, whatever the signs.
  - Signs differ: the positive operand is greater.
  - Both positive: the larger magnitude is greater.
  - Both negative: the larger magnitude is less.
  - Equal bits: equal.
  - Infinities order by this rule with no special case.
- Ties keep the stored extremum; the first occurrence wins.
- States:
  - IDLE: no non-NaN sample yet in the current frame.
    - A non-NaN sample loads min = max = sample, sets count = 1, last_cmp = 000, and moves to ACCUM.
    - A NaN sample increments the NaN counter and stays in IDLE.
    - in_last moves to HOLD regardless of sample type.
  - ACCUM: each non-NaN sample updates min and max, sets last_cmp from the comparison against the previous non-NaN sample, and increments count.
    - in_last moves to HOLD.
  - HOLD: out_valid = 1; all out_* held stable.
    - out_ready = 1 moves to IDLE and clears the count, NaN, min, max and last-sample registers.
- in_ready = 1 in IDLE and ACCUM, 0 in HOLD. It is decoded from the state register, with no combinational path from out_ready.
- Counters saturate at 2^CNT_W - 1 and never wrap.
- out_empty = 1 when the frame closes from IDLE. In that case out_min = out_max = 16'h7E00 and out_count = 0.

## Timing
- Reset values:
  - State IDLE, in_ready 1, out_valid 0.
  - out_min and out_max 16'h0000.
  - out_count and out_nan 0.
  - out_empty 0, last_cmp 3'b000.
- last_cmp, out_count and the internal min/max registers update on the edge that accepts the sample.
- Result latency: the in_last sample accepted at edge N gives out_valid = 1 after edge N, and the result includes that sample.
- Output handshake: the result is taken at the edge where out_valid && out_ready.
  - in_ready returns to 1 after that edge.
  - There is no same-cycle bypass, so a new frame starts one cycle later at the earliest.
- in_valid during HOLD is ignored and not consumed. The upstream source holds its data.
- in_last on a NaN sample closes the frame normally.
- Reset mid-frame: the frame is discarded and all registers take their reset values immediately. No partial result is emitted.
- Throughput: one sample per cycle in IDLE and ACCUM.

## Test plan
- Basic frame: 3C00, 4000, BC00 (last) back-to-back.
  - Required: out_min BC00, out_max 4000, out_count 3, out_nan 0, out_empty 0.
  - last_cmp sequence 000, 010, 100.
  - out_valid exactly one cycle after the last accept.
- Signed zeros: 8000, 0000 (last).
  - Required: last_cmp 001, out_min 8000, out_max 8000, out_count 2.
- NaN and infinity: 7E00, C000, 7C00, 7E01 (last).
  - Required: out_min C000, out_max 7C00, out_count 2, out_nan 2, out_empty 0.
- All-NaN frame: single 7E00 (last).
  - Required: out_empty 1, out_min = out_max = 7E00, out_count 0, out_nan 1.
- Backpressure: out_ready low for 5 cycles after out_valid, with in_valid held high on 4000.
  - Required: outputs stable, in_ready 0, nothing consumed.
  - Raise out_ready: out_valid falls and in_ready = 1 on the next cycle.
- Reset and saturation:
  - Pull rst_n low after 2 samples, then send frame 4000 (last). Required: min = max = 4000, count 1.
  - Send a 300-sample frame of 3C00. Required: out_count 255.
